// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with synchronous flush.
// Define PIPE_REG_SKID_EN to add a skid register and make in_ready registered.
module pipe_stage_reg #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   logic             r_m_valid;
   logic [WIDTH-1:0] r_m_data;
   logic             w_accept;
   logic             w_drain;

   assign w_accept  = in_valid && in_ready;
   assign w_drain   = r_m_valid && out_ready;
   assign out_valid = r_m_valid;
   assign out_data  = r_m_data;

`ifdef PIPE_REG_SKID_EN
   logic             r_s_valid;
   logic [WIDTH-1:0] r_s_data;

   // in_ready depends only on state, so out_ready never reaches it combinationally.
   assign in_ready  = !r_s_valid;
   assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
         r_m_data  <= RESET_VALUE;
         r_s_data  <= RESET_VALUE;
      end else if (flush) begin
         // NOTE: flush clears only the valid bits; data registers keep their contents.
         r_m_valid <= 1'b0;
         r_s_valid <= 1'b0;
      end else if (!r_m_valid || w_drain) begin
         if (r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
         end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
         end else begin
            r_m_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_s_valid <= 1'b1;
         r_s_data  <= in_data;
      end
   end
`else
   assign in_ready  = !r_m_valid || out_ready;
   assign occupancy = {1'b0, r_m_valid};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_valid <= 1'b0;
         r_m_data  <= RESET_VALUE;
      end else if (flush) begin
         // NOTE: flush clears only the valid bit; the data register keeps its contents.
         r_m_valid <= 1'b0;
      end else if (w_accept) begin
         r_m_valid <= 1'b1;
         r_m_data  <= in_data;
      end else if (w_drain) begin
         r_m_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: constant vector table, directed corner
// sequences and a random run against a FIFO scoreboard. Honours PIPE_REG_SKID_EN.
module tb_pipe_stage_reg;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] sb[$];
   logic         acc;

   typedef struct {
      logic         in_valid;
      logic [W-1:0] in_data;
      logic         out_ready;
      logic         exp_valid;
      logic [W-1:0] exp_data;
      logic         exp_ready;
      logic [1:0]   exp_occ;
   } vec_t;

   vec_t tbl[6];

   pipe_stage_reg #(.WIDTH(W), .RESET_VALUE('0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle, compare outputs against the scoreboard, then advance the model past the edge.
   task automatic sb_cycle(input logic iv, input logic [W-1:0] id, input logic ordy,
                           input logic fl, output logic accepted);
      logic exp_rdy;
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
`ifdef PIPE_REG_SKID_EN
      exp_rdy = (sb.size() < 2);
`else
      exp_rdy = (sb.size() == 0) || ordy;
`endif
      check("out_valid", W'(out_valid), W'(sb.size() > 0));
      check("occupancy", W'(occupancy), W'(sb.size()));
      check("in_ready", W'(in_ready), W'(exp_rdy));
      if (sb.size() > 0) check("out_data", out_data, sb[0]);
      accepted = iv && exp_rdy && !fl;
      if (fl) begin
         sb.delete();
      end else begin
         if (sb.size() > 0 && ordy) void'(sb.pop_front());
         if (iv && exp_rdy) sb.push_back(id);
      end
      @(posedge clk);
      #1;
   endtask

   // Hold an offer upstream until accepted, bounded by a cycle budget.
   task automatic offer_until_taken(input logic [W-1:0] d, input logic ordy);
      logic a;
      int   n;
      a = 1'b0;
      n = 0;
      while (!a && n < 8) begin
         sb_cycle(1'b1, d, ordy, 1'b0, a);
         n++;
      end
      check("offer_taken_within_budget", W'(a), W'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Streaming vectors: identical in both builds, 1-cycle latency, in_ready stays high.
      tbl[0] = '{1'b1, 32'd1, 1'b1, 1'b0, 32'd0, 1'b1, 2'd0};
      tbl[1] = '{1'b1, 32'd2, 1'b1, 1'b1, 32'd1, 1'b1, 2'd1};
      tbl[2] = '{1'b1, 32'd3, 1'b1, 1'b1, 32'd2, 1'b1, 2'd1};
      tbl[3] = '{1'b1, 32'd4, 1'b1, 1'b1, 32'd3, 1'b1, 2'd1};
      tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd4, 1'b1, 2'd1};
      tbl[5] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1, 2'd0};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_data", out_data, W'(0));
      check("rst_occupancy", W'(occupancy), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      #11 rst = 1'b0;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         in_valid  = tbl[i].in_valid;
         in_data   = tbl[i].in_data;
         out_ready = tbl[i].out_ready;
         #1;
         check($sformatf("stream%0d_out_valid", i), W'(out_valid), W'(tbl[i].exp_valid));
         check($sformatf("stream%0d_in_ready", i), W'(in_ready), W'(tbl[i].exp_ready));
         check($sformatf("stream%0d_occupancy", i), W'(occupancy), W'(tbl[i].exp_occ));
         if (tbl[i].exp_valid) check($sformatf("stream%0d_out_data", i), out_data, tbl[i].exp_data);
         @(posedge clk);
         #1;
      end
      sb.delete();

`ifdef PIPE_REG_SKID_EN
      // Backpressure: two accepts, third offer held, then ordered release.
      offer_until_taken(32'hA, 1'b0);
      offer_until_taken(32'hB, 1'b0);
      sb_cycle(1'b1, 32'hC, 1'b0, 1'b0, acc);
      check("bp_c_refused", W'(acc), W'(0));
      check("bp_occupancy_full", W'(occupancy), W'(2));
      check("bp_in_ready_low", W'(in_ready), W'(0));
      offer_until_taken(32'hC, 1'b1);
      for (int i = 0; i < 4; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, acc);
      check("bp_drained", W'(sb.size()), W'(0));
`else
      // Combinational in_ready: follows out_ready within the cycle; accept and drain on one edge.
      sb_cycle(1'b1, 32'h77, 1'b0, 1'b0, acc);
      in_valid = 1'b1; in_data = 32'h88; out_ready = 1'b0;
      #1;
      check("ns_in_ready_stalled", W'(in_ready), W'(0));
      out_ready = 1'b1;
      #1;
      check("ns_in_ready_released", W'(in_ready), W'(1));
      sb_cycle(1'b1, 32'h88, 1'b1, 1'b0, acc);
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("ns_swap_out_data", out_data, 32'h88);
      check("ns_swap_occupancy", W'(occupancy), W'(1));
      sb_cycle(1'b0, '0, 1'b1, 1'b0, acc);
`endif

      // Flush with a simultaneous offer: everything squashed, 0x55 never appears.
      offer_until_taken(32'h11, 1'b0);
`ifdef PIPE_REG_SKID_EN
      offer_until_taken(32'h22, 1'b0);
`endif
      sb_cycle(1'b1, 32'h55, 1'b0, 1'b1, acc);
      in_valid = 1'b0;
      #1;
      check("flush_out_valid", W'(out_valid), W'(0));
      check("flush_occupancy", W'(occupancy), W'(0));
      check("flush_in_ready", W'(in_ready), W'(1));
      for (int i = 0; i < 3; i++) sb_cycle(1'b0, '0, 1'b1, 1'b0, acc);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 10000; i++) begin
         sb_cycle(1'(($urandom_range(0, 3)) != 0), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 31) == 0), acc);
      end
      sb_cycle(1'b0, '0, 1'b0, 1'b1, acc);

      // Asynchronous reset mid-stream drops held entries at once.
      offer_until_taken(32'h31, 1'b0);
`ifdef PIPE_REG_SKID_EN
      offer_until_taken(32'h32, 1'b0);
`endif
      in_valid = 1'b0; out_ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("amid_rst_out_valid", W'(out_valid), W'(0));
      check("amid_rst_out_data", out_data, W'(0));
      check("amid_rst_occupancy", W'(occupancy), W'(0));
      check("amid_rst_in_ready", W'(in_ready), W'(1));
      #1 rst = 1'b0;
      sb.delete();
      sb_cycle(1'b1, 32'h99, 1'b1, 1'b0, acc);
      check("post_rst_accept", W'(acc), W'(1));
      sb_cycle(1'b0, '0, 1'b1, 1'b0, acc);
      sb_cycle(1'b0, '0, 1'b1, 1'b0, acc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
